// File: rtl/alu_fifo_pkg.sv
// alu_fifo_pkg: default parameter set for the ALU result FIFO and the
// queue entry layout {result, flags}.
package alu_fifo_pkg;
  localparam int BUS_W_DEF  = 8;
  localparam int SLICES_DEF = 2;
  localparam int DEPTH_DEF  = 4;
  localparam int FLAG_W_DEF = 3;
  localparam int RES_W_DEF  = BUS_W_DEF * SLICES_DEF;

  // Entry at the default widths. Modules with overridden parameters build
  // the same {result, flags} layout from their own widths.
  typedef struct packed {
    logic [RES_W_DEF-1:0]  result;
    logic [FLAG_W_DEF-1:0] flags;
  } entry_t;

  // Bits needed to hold one queued entry.
  function automatic int entry_width(input int res_w, input int flag_w);
    return res_w + flag_w;
  endfunction
endpackage

// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if: ALU-side inputs, bus-side output and status of the
// ALU result FIFO.
//   master : drives grab/alu_result/flags_in/store/stream/slice_sel/pop
//   slave  : drives data_out (tri-state), flags_out, count, full, empty,
//            overflow, underflow
interface alu_result_fifo_if
  import alu_fifo_pkg::*;
#(
  parameter int BUS_W  = BUS_W_DEF,
  parameter int SLICES = SLICES_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int FLAG_W = FLAG_W_DEF
);
  localparam int RES_W = BUS_W * SLICES;

  logic                       grab;
  logic [RES_W-1:0]           alu_result;
  logic [FLAG_W-1:0]          flags_in;
  logic                       store;
  logic                       stream;
  logic [$clog2(SLICES)-1:0]  slice_sel;
  logic                       pop;
  logic [BUS_W-1:0]           data_out;
  logic [FLAG_W-1:0]          flags_out;
  logic [$clog2(DEPTH):0]     count;
  logic                       full;
  logic                       empty;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output grab, alu_result, flags_in, store, stream, slice_sel, pop,
    input  data_out, flags_out, count, full, empty, overflow, underflow
  );

  modport slave (
    input  grab, alu_result, flags_in, store, stream, slice_sel, pop,
    output data_out, flags_out, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/alu_fifo_core.sv
// alu_fifo_core: DEPTH-entry queue of {result, flags}.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   push_i, pop_i      : push / pop requests (qualified here)
//   wr_result_i/flags_i: entry written at the tail
//   rd_result_o/flags_o: current head entry (combinational read)
//   count_o, full_o, empty_o : occupancy
module alu_fifo_core #(
  parameter int DEPTH  = 4,
  parameter int RES_W  = 16,
  parameter int FLAG_W = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [RES_W-1:0]        wr_result_i,
  input  logic [FLAG_W-1:0]       wr_flags_i,
  output logic [RES_W-1:0]        rd_result_o,
  output logic [FLAG_W-1:0]       rd_flags_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [RES_W-1:0]  result;
    logic [FLAG_W-1:0] flags;
  } fifo_entry_t;

  fifo_entry_t mem_q [DEPTH];
  fifo_entry_t head;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (count_o == '0);

  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign do_push = push_i & (~full_o | do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only observed through count.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{result: wr_result_i, flags: wr_flags_i};
    end
  end

  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_result_o = head.result;
  assign rd_flags_o  = head.flags;
endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: queues ALU results with flags and puts one BUS_W slice
// of the head entry on the shared tri-state bus per store cycle.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : alu_result_fifo_if.slave (ALU inputs, bus drive, status)
module alu_result_fifo
  import alu_fifo_pkg::*;
#(
  parameter int BUS_W  = BUS_W_DEF,
  parameter int SLICES = SLICES_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int FLAG_W = FLAG_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  alu_result_fifo_if.slave   bus
);
  localparam int RES_W = BUS_W * SLICES;
  localparam int SW    = $clog2(SLICES);

  logic [RES_W-1:0]       head_result;
  logic [FLAG_W-1:0]      head_flags;
  logic [$clog2(DEPTH):0] count;
  logic                   full, empty;

  logic [BUS_W-1:0] slice_arr [SLICES];
  logic [SW-1:0]    sel, slice_ptr_q, slice_ptr_d;
  logic [BUS_W-1:0] data_q, data_d;
  logic             drive_q, drive_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             store_ok, auto_pop, pop_req, pop_eff;

  alu_fifo_core #(.DEPTH(DEPTH), .RES_W(RES_W), .FLAG_W(FLAG_W)) u_core (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (bus.grab),
    .pop_i       (pop_req),
    .wr_result_i (bus.alu_result),
    .wr_flags_i  (bus.flags_in),
    .rd_result_o (head_result),
    .rd_flags_o  (head_flags),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Slice 0 is the most significant BUS_W bits of the result.
  for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
    assign slice_arr[gi] = head_result[RES_W-1-gi*BUS_W -: BUS_W];
  end

  assign sel      = bus.stream ? slice_ptr_q : bus.slice_sel;
  assign store_ok = bus.store & ~empty;
  // Streaming the last slice retires the entry; an explicit pop in the same
  // cycle merges into the same single pop.
  assign auto_pop = store_ok & bus.stream & (slice_ptr_q == SW'(SLICES-1));
  assign pop_req  = auto_pop | bus.pop;
  assign pop_eff  = pop_req & ~empty;

  always_comb begin
    slice_ptr_d = slice_ptr_q;
    data_d      = data_q;
    drive_d     = store_ok;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (pop_eff) begin
      slice_ptr_d = '0;
    end else if (store_ok && bus.stream) begin
      slice_ptr_d = slice_ptr_q + 1'b1;
    end
    if (store_ok) begin
      data_d = slice_arr[sel];
    end
    // full implies non-empty, so any pop request frees a slot.
    if (bus.grab && full && !pop_req) begin
      ovf_d = 1'b1;
    end
    if (empty && (bus.store || bus.pop)) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slice_ptr_q <= '0;
      data_q      <= '0;
      drive_q     <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      slice_ptr_q <= slice_ptr_d;
      data_q      <= data_d;
      drive_q     <= drive_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  always_comb begin
    bus.data_out = drive_q ? data_q : {BUS_W{1'bz}};
  end

  assign bus.flags_out = empty ? '0 : head_flags;
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule
